// File: rtl/pipe_pkg.sv
// Shared types and helpers for the pipeline control chain.
package pipe_pkg;

  // Event counter width.
  localparam int CNT_W = 16;

  // Stage entries carry payload/address at these maximum widths; the top
  // zero-extends on entry and slices back down on the way out.
  localparam int MAX_DATA_W = 64;
  localparam int MAX_REG_AW = 8;

  typedef struct packed {
    logic                  valid;
    logic                  wr;
    logic [MAX_REG_AW-1:0] dest;
    logic [MAX_DATA_W-1:0] data;
  } stage_ent_t;

  // Width of a stage index (at least one bit).
  function automatic int STAGE_IDX_W(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Saturating increment for the event counters.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/pipe_stage_reg.sv
// One pipeline stage register: flush > hold > bubble > advance.
module pipe_stage_reg
  import pipe_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       flush_i,
  input  logic       hold_i,
  input  logic       bubble_i,
  input  stage_ent_t d_i,
  output stage_ent_t q_o
);

  stage_ent_t ent_q;

  // Stage update in priority order; flush and bubble only drop valid.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ent_q <= '0;
    end else if (flush_i) begin
      ent_q.valid <= 1'b0;
    end else if (!hold_i) begin
      if (bubble_i) ent_q.valid <= 1'b0;
      else          ent_q       <= d_i;
    end
  end

  assign q_o = ent_q;

endmodule

// File: rtl/pipe_ctrl_chain.sv
// Pipeline control chain: stall propagation, per-stage flush, bubble
// insertion, combinational operand forwarding and saturating event counters.
// DATA_W must not exceed MAX_DATA_W and REG_AW must not exceed MAX_REG_AW.
module pipe_ctrl_chain
  import pipe_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int STAGES = 4,
  parameter int REG_AW = 5
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  input  logic [DATA_W-1:0]              in_data,
  input  logic [REG_AW-1:0]              in_dest,
  input  logic                           in_wr,
  output logic                           in_ready,
  input  logic [STAGES-1:0]              stall_req,
  input  logic [STAGES-1:0]              flush,
  output logic                           out_valid,
  output logic [DATA_W-1:0]              out_data,
  output logic [REG_AW-1:0]              out_dest,
  output logic                           out_wr,
  input  logic [REG_AW-1:0]              src_a,
  input  logic [REG_AW-1:0]              src_b,
  output logic                           fwd_a_hit,
  output logic                           fwd_b_hit,
  output logic [STAGE_IDX_W(STAGES)-1:0] fwd_a_stage,
  output logic [STAGE_IDX_W(STAGES)-1:0] fwd_b_stage,
  output logic [DATA_W-1:0]              fwd_a_data,
  output logic [DATA_W-1:0]              fwd_b_data,
  input  logic                           cnt_clr,
  output logic [CNT_W-1:0]               stall_cnt,
  output logic [CNT_W-1:0]               bubble_cnt,
  output logic [CNT_W-1:0]               flush_cnt
);

  localparam int SW = STAGE_IDX_W(STAGES);

  stage_ent_t [STAGES-1:0] stg_q;
  stage_ent_t [STAGES-1:0] stg_d;
  logic       [STAGES-1:0] hold;
  logic       [STAGES-1:0] bubble;
  logic                    bubble_ev;

  logic [CNT_W-1:0] stall_cnt_q,  stall_cnt_d;
  logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q,  flush_cnt_d;

  // A stall anywhere freezes that stage and everything younger; the first
  // unheld stage past a held one receives a bubble.
  genvar g;
  generate
    for (g = 0; g < STAGES; g++) begin : g_stage
      assign hold[g] = |stall_req[STAGES-1:g];

      if (g == 0) begin : g_head
        assign bubble[g] = 1'b0;
        assign stg_d[g]  = '{valid: in_valid & in_ready,
                             wr:    in_wr,
                             dest:  MAX_REG_AW'(in_dest),
                             data:  MAX_DATA_W'(in_data)};
      end else begin : g_body
        assign bubble[g] = hold[g-1] & ~hold[g];
        assign stg_d[g]  = stg_q[g-1];
      end

      pipe_stage_reg u_stage (
        .clk_i    (clk),
        .rst_i    (rst),
        .flush_i  (flush[g]),
        .hold_i   (hold[g]),
        .bubble_i (bubble[g]),
        .d_i      (stg_d[g]),
        .q_o      (stg_q[g])
      );
    end
  endgenerate

  assign in_ready = ~hold[0] & ~flush[0];

  // Oldest stage drives the output port directly.
  assign out_valid = stg_q[STAGES-1].valid;
  assign out_wr    = stg_q[STAGES-1].valid & stg_q[STAGES-1].wr;
  assign out_data  = stg_q[STAGES-1].data[DATA_W-1:0];
  assign out_dest  = stg_q[STAGES-1].dest[REG_AW-1:0];

  // Upper payload/address bits exist only to fit the shared entry type.
  logic unused_ent;
  assign unused_ent = ^stg_q;

  // Forwarding: youngest matching writer wins, so scan oldest-to-youngest
  // and let each later match override. Register 0 never forwards.
  always_comb begin
    fwd_a_hit   = 1'b0;
    fwd_a_stage = '0;
    fwd_a_data  = '0;
    fwd_b_hit   = 1'b0;
    fwd_b_stage = '0;
    fwd_b_data  = '0;
    for (int i = STAGES-1; i >= 0; i--) begin
      if (stg_q[i].valid && stg_q[i].wr && (src_a != '0) &&
          (stg_q[i].dest == MAX_REG_AW'(src_a))) begin
        fwd_a_hit   = 1'b1;
        fwd_a_stage = SW'(i);
        fwd_a_data  = stg_q[i].data[DATA_W-1:0];
      end
      if (stg_q[i].valid && stg_q[i].wr && (src_b != '0) &&
          (stg_q[i].dest == MAX_REG_AW'(src_b))) begin
        fwd_b_hit   = 1'b1;
        fwd_b_stage = SW'(i);
        fwd_b_data  = stg_q[i].data[DATA_W-1:0];
      end
    end
  end

  // A bubble that coincides with a flush of the same stage is not inserted.
  assign bubble_ev = |(bubble & ~flush);

  // Counter next-state: clear wins over increment, increments saturate.
  always_comb begin
    stall_cnt_d  = stall_cnt_q;
    bubble_cnt_d = bubble_cnt_q;
    flush_cnt_d  = flush_cnt_q;
    if (cnt_clr) begin
      stall_cnt_d  = '0;
      bubble_cnt_d = '0;
      flush_cnt_d  = '0;
    end else begin
      if (hold[0])        stall_cnt_d  = sat_inc(stall_cnt_q);
      if (bubble_ev)      bubble_cnt_d = sat_inc(bubble_cnt_q);
      if (flush != '0)    flush_cnt_d  = sat_inc(flush_cnt_q);
    end
  end

  // Counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q  <= '0;
      bubble_cnt_q <= '0;
      flush_cnt_q  <= '0;
    end else begin
      stall_cnt_q  <= stall_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
      flush_cnt_q  <= flush_cnt_d;
    end
  end

  assign stall_cnt  = stall_cnt_q;
  assign bubble_cnt = bubble_cnt_q;
  assign flush_cnt  = flush_cnt_q;

endmodule

// File: tb/tb_pipe_ctrl_chain.sv
// Bench for pipe_ctrl_chain: directed scenarios with literal expectations
// plus a per-cycle comparison against a behavioural model.
module tb_pipe_ctrl_chain;

  localparam int DW = 32;
  localparam int ST = 4;
  localparam int AW = 5;
  localparam int SW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic [AW-1:0] in_dest;
  logic          in_wr;
  logic          in_ready;
  logic [ST-1:0] stall_req;
  logic [ST-1:0] flush;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic [AW-1:0] out_dest;
  logic          out_wr;
  logic [AW-1:0] src_a, src_b;
  logic          fwd_a_hit, fwd_b_hit;
  logic [SW-1:0] fwd_a_stage, fwd_b_stage;
  logic [DW-1:0] fwd_a_data, fwd_b_data;
  logic          cnt_clr;
  logic [15:0]   stall_cnt, bubble_cnt, flush_cnt;

  pipe_ctrl_chain #(.DATA_W(DW), .STAGES(ST), .REG_AW(AW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_data(in_data), .in_dest(in_dest), .in_wr(in_wr),
    .in_ready(in_ready), .stall_req(stall_req), .flush(flush),
    .out_valid(out_valid), .out_data(out_data), .out_dest(out_dest), .out_wr(out_wr),
    .src_a(src_a), .src_b(src_b),
    .fwd_a_hit(fwd_a_hit), .fwd_b_hit(fwd_b_hit),
    .fwd_a_stage(fwd_a_stage), .fwd_b_stage(fwd_b_stage),
    .fwd_a_data(fwd_a_data), .fwd_b_data(fwd_b_data),
    .cnt_clr(cnt_clr), .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_tot  = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tot++;
    if (act !== exp) $display("FAIL %s actual=%0h required=%0h @%0t", nm, act, exp, $time);
    else n_pass++;
  endtask

  // ---------------- behavioural model ----------------
  typedef struct { bit v; bit wr; int dest; longint data; } ent_t;
  ent_t   m [ST];
  ent_t   nx [ST];
  int     m_stall, m_bub, m_flush;
  bit     hld [ST];
  bit     bub_any;
  bit     chk_en = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ST; i++) m[i] <= '{0, 0, 0, 0};
      m_stall <= 0; m_bub <= 0; m_flush <= 0;
    end else begin
      bub_any = 1'b0;
      for (int i = 0; i < ST; i++) hld[i] = (stall_req >> i) != 0;
      for (int i = 0; i < ST; i++) begin
        if (flush[i]) begin
          nx[i] = m[i]; nx[i].v = 1'b0;
        end else if (hld[i]) begin
          nx[i] = m[i];
        end else if (i > 0 && hld[i-1]) begin
          nx[i] = m[i]; nx[i].v = 1'b0; bub_any = 1'b1;
        end else if (i == 0) begin
          nx[0] = '{in_valid, in_wr, int'(in_dest), longint'(in_data)};
        end else begin
          nx[i] = m[i-1];
        end
      end
      m <= nx;
      if (cnt_clr) begin
        m_stall <= 0; m_bub <= 0; m_flush <= 0;
      end else begin
        if (hld[0] && m_stall < 65535)      m_stall <= m_stall + 1;
        if (bub_any && m_bub < 65535)       m_bub   <= m_bub + 1;
        if (flush != 0 && m_flush < 65535)  m_flush <= m_flush + 1;
      end
    end
  end

  function automatic void mfwd(input int src, output bit hit, output int stg, output longint data);
    hit = 0; stg = 0; data = 0;
    if (src != 0)
      for (int i = 0; i < ST; i++)
        if (!hit && m[i].v && m[i].wr && m[i].dest == src) begin
          hit = 1; stg = i; data = m[i].data;
        end
  endfunction

  bit     e_hit;
  int     e_stg;
  longint e_dat;

  // Per-cycle comparison, away from the active edge.
  always @(negedge clk) begin
    if (chk_en && !rst) begin
      chk("m_in_ready", in_ready, (stall_req == 0) && !flush[0]);
      chk("m_out_valid", out_valid, m[ST-1].v);
      chk("m_out_wr", out_wr, m[ST-1].v && m[ST-1].wr);
      if (m[ST-1].v) begin
        chk("m_out_data", out_data, m[ST-1].data);
        chk("m_out_dest", out_dest, m[ST-1].dest);
      end
      mfwd(int'(src_a), e_hit, e_stg, e_dat);
      chk("m_fwd_a_hit", fwd_a_hit, e_hit);
      chk("m_fwd_a_stage", fwd_a_stage, e_stg);
      chk("m_fwd_a_data", fwd_a_data, e_dat);
      mfwd(int'(src_b), e_hit, e_stg, e_dat);
      chk("m_fwd_b_hit", fwd_b_hit, e_hit);
      chk("m_fwd_b_stage", fwd_b_stage, e_stg);
      chk("m_fwd_b_data", fwd_b_data, e_dat);
      chk("m_stall_cnt", stall_cnt, m_stall);
      chk("m_bubble_cnt", bubble_cnt, m_bub);
      chk("m_flush_cnt", flush_cnt, m_flush);
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic feed(input int dest, input int data);
    in_valid = 1'b1; in_dest = AW'(dest); in_data = DW'(data); in_wr = 1'b1;
    step();
  endtask

  initial begin
    rst = 1'b1; in_valid = 0; in_data = 0; in_dest = 0; in_wr = 0;
    stall_req = 0; flush = 0; src_a = 0; src_b = 0; cnt_clr = 0;
    step(); step();
    rst = 1'b0; #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_wr", out_wr, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_dest", out_dest, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_fwd_a_hit", fwd_a_hit, 0);
    chk("rst_fwd_a_stage", fwd_a_stage, 0);
    chk("rst_fwd_a_data", fwd_a_data, 0);
    chk("rst_stall_cnt", stall_cnt, 0);
    chk("rst_bubble_cnt", bubble_cnt, 0);
    chk("rst_flush_cnt", flush_cnt, 0);
    chk_en = 1'b1;

    // Stream: first entry out three edges after acceptance.
    for (int k = 1; k <= 4; k++) feed(k, 'h11 * k);
    chk("stream_first_valid", out_valid, 1);
    chk("stream_first_data", out_data, 'h11);
    chk("stream_first_dest", out_dest, 1);
    chk("stream_first_wr", out_wr, 1);
    in_valid = 1'b0;
    for (int k = 2; k <= 4; k++) begin
      step();
      chk("stream_data", out_data, 'h11 * k);
    end
    step();
    chk("stream_drained", out_valid, 0);

    // Stall at stage 2 for two cycles.
    for (int k = 1; k <= 4; k++) feed(k, 'h11 * k);
    in_valid = 1'b1; in_dest = 6; in_data = 'h66; in_wr = 1'b1;
    stall_req = 4'b0100; #1;
    chk("stall_in_ready", in_ready, 0);
    step();
    chk("stall_bubble1", out_valid, 0);
    step();
    chk("stall_bubble2", out_valid, 0);
    chk("stall_cnt2", stall_cnt, 2);
    chk("bubble_cnt2", bubble_cnt, 2);
    stall_req = 0;
    step();
    in_valid = 1'b0;
    chk("stall_resume", out_data, 'h22);

    // Flush and stall on stage 1 together; no same-cycle forwarding mask.
    flush = 4'b0010; stall_req = 4'b0010; src_a = 4; #1;
    chk("fl_same_cycle_hit", fwd_a_hit, 1);
    chk("fl_same_cycle_stage", fwd_a_stage, 1);
    chk("fl_same_cycle_data", fwd_a_data, 'h44);
    step();
    flush = 0; stall_req = 0; #1;
    chk("fl_flush_cnt", flush_cnt, 1);
    chk("fl_stage1_gone", fwd_a_hit, 0);
    chk("fl_out_data", out_data, 'h33);
    step(); chk("fl_drain_a", out_valid, 0);
    step(); chk("fl_drain_b", out_valid, 0);
    step(); chk("fl_drain_c", out_data, 'h66);
    src_a = 0;

    // Forwarding: youngest writer wins, register 0 never hits.
    feed(5, 'hB); feed(7, 'hC); feed(5, 'hA); feed(9, 'hD);
    in_valid = 1'b0; src_a = 5; src_b = 0; #1;
    chk("fwd_a_hit", fwd_a_hit, 1);
    chk("fwd_a_stage", fwd_a_stage, 1);
    chk("fwd_a_data", fwd_a_data, 'hA);
    chk("fwd_b_hit", fwd_b_hit, 0);
    chk("fwd_b_stage", fwd_b_stage, 0);
    chk("fwd_b_data", fwd_b_data, 0);
    flush = 4'b0010;
    step();
    flush = 0; #1;
    chk("fwd_after_flush_stage", fwd_a_stage, 2);
    chk("fwd_after_flush_data", fwd_a_data, 'hA);
    src_a = 0;

    // Saturation.
    cnt_clr = 1'b1; step(); cnt_clr = 1'b0;
    chk("sat_clr0", stall_cnt, 0);
    stall_req = 4'b0001;
    repeat (65540) step();
    chk("sat_stall", stall_cnt, 'hFFFF);
    chk("sat_bubble", bubble_cnt, 'hFFFF);
    cnt_clr = 1'b1; step(); cnt_clr = 1'b0;
    chk("sat_clr_stall", stall_cnt, 0);
    chk("sat_clr_bubble", bubble_cnt, 0);
    stall_req = 0;

    // Mid-stream reset discards in-flight entries.
    for (int k = 1; k <= 4; k++) feed(k, 'h10 + k);
    in_valid = 1'b0;
    chk("mid_full", out_valid, 1);
    rst = 1'b1; step(); rst = 1'b0;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_stall_cnt", stall_cnt, 0);
    for (int k = 0; k < 5; k++) begin
      step();
      chk("mid_no_stale", out_valid, 0);
    end

    step();
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl_chain.md
PIPE_CTRL_CHAIN -- requirements
Module: pipe_ctrl_chain

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning the per-stage result payload width.
REQ-002 SHALL have parameter STAGES, default 4, legal range 2..8, meaning the number of pipeline stages (index 0 youngest, STAGES-1 oldest).
REQ-003 SHALL have parameter REG_AW, default 5, meaning the destination/source register address width.
REQ-004 SHALL use one clock and a synchronous, active-high reset, with ports clk and rst.
REQ-005 SHALL have ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  new entry offered to stage 0
- in_data  in  DATA_W  entry result payload
- in_dest  in  REG_AW  entry destination register
- in_wr  in  1  entry writes the register file
- in_ready  out  1  stage 0 accepts this cycle
- stall_req  in  STAGES  per-stage stall request
- flush  in  STAGES  per-stage flush (CLR)
- out_valid  out  1  oldest stage holds a valid entry
- out_data  out  DATA_W  oldest stage payload
- out_dest  out  REG_AW  oldest stage destination
- out_wr  out  1  oldest stage write enable, gated by valid
- src_a, src_b  in  REG_AW  forwarding lookup addresses
- fwd_a_hit, fwd_b_hit  out  1  forwarding match found
- fwd_a_stage, fwd_b_stage  out  clog2(STAGES)  index of the matching stage
- fwd_a_data, fwd_b_data  out  DATA_W  payload of the matching stage
- cnt_clr  in  1  synchronous counter clear
- stall_cnt, bubble_cnt, flush_cnt  out  16  event counters

Function
REQ-006 SHALL compute hold[i] = OR of stall_req[j] for j = i..STAGES-1, so a stall propagates to all younger stages.
REQ-007 SHALL update each stage per cycle with priority flush[i] > hold[i] > bubble > advance.
- flush[i]: valid<=0.
- hold[i]: all fields kept.
- bubble (i>0, hold[i-1], !hold[i]): valid<=0.
- advance: load from stage i-1, or from the input when i=0.
REQ-008 SHALL drive in_ready = !hold[0] && !flush[0]; an entry is accepted only on in_valid && in_ready, otherwise stage 0 loads valid=0 when advancing.
REQ-009 SHALL give one-stage-per-cycle latency: an unstalled entry accepted at edge N appears on out_* after edge N+STAGES-1.
REQ-010 SHALL drive out_valid, out_data, out_dest and out_wr directly from stage STAGES-1 registers, with out_wr = valid && wr.
REQ-011 SHALL make forwarding lookup combinational: a hit is the lowest-index stage with valid && wr && dest==src && src!=0.
- On a hit: stage index and payload are driven.
- On a miss: hit=0, stage=0, data=0.
REQ-012 SHALL exclude a stage flushed in the current cycle from forwarding only after the flush edge; there is no same-cycle masking.
REQ-013 SHALL update counters each cycle:
- stall_cnt +1 when hold[0].
- bubble_cnt +1 when any stage inserts a bubble; at most +1 per cycle.
- flush_cnt +1 when flush != 0.
- All counters saturate at 0xFFFF.
- cnt_clr zeroes all counters and wins over increment.

Reset
REQ-014 SHALL on rst clear all stage valid, data, dest and wr fields and all counters to 0; rst wins over flush, stall and cnt_clr.
REQ-015 SHALL drive after reset: out_valid=0, out_wr=0, out_data=0, out_dest=0, fwd_*_hit=0, fwd_*_stage=0, fwd_*_data=0, counters 0, and in_ready=1 unless stall_req or flush[0] is asserted.
REQ-016 SHALL discard any in-flight entries when reset is applied mid-operation; none appear on out_* after reset.

Structure
REQ-017 SHALL place in shared package pipe_pkg: the stage-entry struct type (valid, wr, dest, data), the STAGE_IDX_W width function and the counter width constant CNT_W=16.
REQ-018 SHALL instantiate sub-module pipe_stage_reg once per stage, implementing the REQ-007 priority; hold, forwarding and counters live in the top.

Verification
REQ-019 SHALL be verified by these directed scenarios, using STAGES=4 and DATA_W=32:
- Stream: entries dest 1..4, data 0x11..0x44, no stalls -> out_data 0x11 three edges after acceptance, then one entry per cycle.
- Stall: stall_req[2]=1 for 2 cycles -> stages 0..2 hold, stage 3 gets 2 bubbles, in_ready=0, stall_cnt=2, bubble_cnt=2.
- Flush with stall: flush[1]=1 and stall_req[1]=1 in the same cycle -> stage 1 valid=0 (flush wins), flush_cnt=1.
- Forward: stage 1 dest 5 data 0xA, stage 3 dest 5 data 0xB, src_a=5 -> fwd_a_hit=1, stage=1, data=0xA; src_b=0 -> fwd_b_hit=0.
- Saturation: counters preloaded by 65540 stall cycles -> stall_cnt=0xFFFF; cnt_clr -> 0.
- Mid-stream reset: rst pulsed with 4 valid entries -> out_valid=0 next cycle, no stale entry emerges afterwards.
